// File: rtl/floo_mask_extract_seq.sv
// Sequential bit-extract (PEXT-style): compacts the data bits selected by a
// runtime mask into an LSB-aligned word, processing ChunkWidth bits per cycle.
module floo_mask_extract_seq #(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned ChunkWidth = 8
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [DataWidth-1:0]           data_i,
    input  logic [DataWidth-1:0]           mask_i,
    output logic                           valid_o,
    input  logic                           ready_i,
    output logic [DataWidth-1:0]           data_o,
    output logic [$clog2(DataWidth+1)-1:0] count_o,
    output logic                           busy_o
);

    localparam int unsigned NumChunks     = DataWidth / ChunkWidth;
    localparam int unsigned CntWidth      = $clog2(DataWidth + 1);
    localparam int unsigned IdxWidth      = (DataWidth > 1) ? $clog2(DataWidth) : 1;
    localparam int unsigned ChunkIdxWidth = (NumChunks > 1) ? $clog2(NumChunks) : 1;

    localparam logic [1:0] StateIdle = 2'd0;
    localparam logic [1:0] StateBusy = 2'd1;
    localparam logic [1:0] StateDone = 2'd2;

    if ((DataWidth % ChunkWidth) != 0) begin : g_bad_cfg
        $error("DataWidth must be an integer multiple of ChunkWidth");
    end

    logic [1:0]               state_q, state_n;
    logic [DataWidth-1:0]     data_q, data_n;
    logic [DataWidth-1:0]     mask_q, mask_n;
    logic [DataWidth-1:0]     acc_n;
    logic [CntWidth-1:0]      fill_n;
    logic [CntWidth-1:0]      pos;
    logic [ChunkIdxWidth-1:0] chunk_q, chunk_n;
    logic                     ready_n;
    logic                     valid_n;
    logic                     busy_n;

    // State and datapath registers; data_o/count_o are the accumulator and fill pointer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StateIdle;
            data_q  <= '0;
            mask_q  <= '0;
            chunk_q <= '0;
            data_o  <= '0;
            count_o <= '0;
            ready_o <= 1'b1;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_n;
            data_q  <= data_n;
            mask_q  <= mask_n;
            chunk_q <= chunk_n;
            data_o  <= acc_n;
            count_o <= fill_n;
            ready_o <= ready_n;
            valid_o <= valid_n;
            busy_o  <= busy_n;
        end
    end

    // Next-state and chunk processing; sampled words shift down so the low chunk is always current.
    always_comb begin
        state_n = state_q;
        data_n  = data_q;
        mask_n  = mask_q;
        acc_n   = data_o;
        fill_n  = count_o;
        chunk_n = chunk_q;
        pos     = '0;

        case (state_q)
            StateIdle: begin
                if (valid_i) begin
                    state_n = StateBusy;
                    data_n  = data_i;
                    mask_n  = mask_i;
                    acc_n   = '0;
                    fill_n  = '0;
                    chunk_n = '0;
                end
            end
            StateBusy: begin
                pos = count_o;
                for (int unsigned i = 0; i < ChunkWidth; i++) begin
                    if (mask_q[i]) begin
                        // Total set bits never exceed DataWidth; the guard keeps the index in range.
                        if (pos < CntWidth'(DataWidth)) begin
                            acc_n[IdxWidth'(pos)] = data_q[i];
                        end
                        pos = pos + CntWidth'(1);
                    end
                end
                fill_n  = pos;
                data_n  = data_q >> ChunkWidth;
                mask_n  = mask_q >> ChunkWidth;
                chunk_n = chunk_q + ChunkIdxWidth'(1);
                if (chunk_q == ChunkIdxWidth'(NumChunks - 1)) begin
                    state_n = StateDone;
                end
            end
            StateDone: begin
                if (ready_i) begin
                    state_n = StateIdle;
                end
            end
            default: begin
                state_n = StateIdle;
            end
        endcase

        ready_n = (state_n == StateIdle);
        valid_n = (state_n == StateDone);
        busy_n  = (state_n != StateIdle);
    end

endmodule

// File: doc/floo_mask_extract_seq.md
FLOO_MASK_EXTRACT_SEQ -- requirements
Module: floo_mask_extract_seq

Interface
REQ-001 SHALL have parameter DataWidth, default 32: width of the data and runtime-mask words.
REQ-002 SHALL have parameter ChunkWidth, default 8: number of bits processed per cycle; DataWidth SHALL be an integer multiple of ChunkWidth (elaboration-time assertion).
REQ-003 SHALL derive NumChunks = DataWidth/ChunkWidth and CntWidth = $clog2(DataWidth+1).
REQ-004 SHALL have port clk_i  input  1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_i  input  1: reset, synchronous, active-high.
REQ-006 SHALL have port valid_i  input  1: request valid.
REQ-007 SHALL have port ready_o  output  1: request accepted when valid_i && ready_o.
REQ-008 SHALL have port data_i  input  DataWidth: source word.
REQ-009 SHALL have port mask_i  input  DataWidth: runtime mask; set bits select the data_i bits to extract.
REQ-010 SHALL have port valid_o  output  1: result valid.
REQ-011 SHALL have port ready_i  input  1: result consumed when valid_o && ready_i.
REQ-012 SHALL have port data_o  output  DataWidth: compacted result, LSB-aligned, unused upper bits zero.
REQ-013 SHALL have port count_o  output  CntWidth: number of mask bits set (= extracted bits).
REQ-014 SHALL have port busy_o  output  1: high in any state other than IDLE.

Function
REQ-015 SHALL implement an FSM with states IDLE, BUSY, DONE.
REQ-016 IDLE: ready_o=1, valid_o=0; on valid_i, SHALL register data_i and mask_i, clear the accumulator, fill pointer and chunk index, and go to BUSY.
REQ-017 BUSY: each cycle SHALL process chunk k (bits [k*ChunkWidth +: ChunkWidth]): the data bits at set mask positions, in ascending bit order, SHALL be written into the accumulator starting at the fill pointer; the fill pointer SHALL advance by the popcount of the chunk mask; k SHALL increment.
REQ-018 BUSY SHALL last exactly NumChunks cycles regardless of mask content (all-zero chunks are not skipped); after chunk NumChunks-1 the FSM SHALL go to DONE.
REQ-019 DONE: valid_o=1, data_o = accumulator, count_o = fill pointer; outputs SHALL be held stable until ready_i; on valid_o && ready_i the FSM SHALL go to IDLE.
REQ-020 ready_o SHALL be 0 in BUSY and DONE; valid_i in those states SHALL be ignored and SHALL NOT alter state.
REQ-021 Latency: with acceptance at edge t, valid_o SHALL first be high in the cycle after edge t+NumChunks; minimum interval between acceptances is NumChunks+2 cycles.
REQ-022 Result SHALL equal static extraction: bit j of data_o = data_i bit at position of the (j+1)-th set mask bit (from LSB), for j < count_o; bits j >= count_o SHALL be 0.
REQ-023 Fill pointer SHALL be CntWidth bits wide and SHALL never exceed DataWidth; accumulator writes SHALL never index beyond DataWidth-1.
REQ-024 data_i and mask_i need not be held after acceptance; the result SHALL depend only on the values sampled at acceptance.
REQ-025 data_o and count_o outside DONE SHALL reflect the partial accumulator and fill pointer; consumers SHALL use them only when valid_o is high.

Reset
REQ-026 On rst_i high at a rising edge, the FSM SHALL enter IDLE and accumulator, fill pointer, chunk index and sampled registers SHALL clear to 0, in any state, including mid-BUSY or in DONE with ready_i low.
REQ-027 Reset values: ready_o=1 (while rst_i low in IDLE), valid_o=0, busy_o=0, data_o=0, count_o=0; rst_i high SHALL take priority over valid_i and ready_i in the same cycle.

Verification (DataWidth=32, ChunkWidth=8)
REQ-028 SHALL test mask 0x0000000A, data 0x0000000D -> data_o 0x00000002, count_o 2, valid_o high 4 cycles after accept edge.
REQ-029 SHALL test mask 0xFFFFFFFF, data 0xDEADBEEF -> data_o 0xDEADBEEF, count_o 32; mask 0x00000000, any data -> data_o 0, count_o 0, same 4-cycle latency.
REQ-030 SHALL test mask 0xF0F0F0F0, data 0x12345678 -> data_o 0x00001357, count_o 16.
REQ-031 SHALL test ready_i held low 5 cycles in DONE with valid_i toggling -> valid_o, data_o, count_o stable, ready_o 0, no new request accepted; ready_i high -> IDLE next cycle.
REQ-032 SHALL test rst_i pulsed during BUSY chunk 2 -> next cycle IDLE, valid_o 0, busy_o 0, count_o 0, ready_o 1; a following request completes correctly.
REQ-033 SHALL run a randomized mask/data sweep with random ready_i backpressure against a reference model -> zero mismatches.
